// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared op codes, FSM states and op-class helpers for the HI/LO
// multiply/divide unit.
package hilo_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MFHI  = 4'd9,
        OP_MFLO  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU ||
               op == OP_MADD || op == OP_MSUB;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op == OP_MULT || op == OP_DIV ||
               op == OP_MADD || op == OP_MSUB;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Valid;
    logic [3:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Stall;
    logic             Busy;
    logic [WIDTH-1:0] ReadData;
    logic             ReadValid;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Done;

    modport master (
        output Valid, Op, A, B, Flush,
        input  Stall, Busy, ReadData, ReadValid,
        input  Hi, Lo, Done
    );

    modport slave (
        input  Valid, Op, A, B, Flush,
        output Stall, Busy, ReadData, ReadValid,
        output Hi, Lo, Done
    );
endinterface

// File: rtl/hilo_muldiv_unit_core.sv
// One-bit-per-step datapath: right-shift shift-add multiply or
// restoring divide on unsigned magnitudes.
module hilo_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // lo holds multiplier (mul) or dividend/quotient (div); m_q the other operand
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, m_q};
        diff    = shifted[WIDTH-1:0] - m_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi  <= '0;
            lo  <= '0;
            m_q <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a;
            m_q <= b;
        end else if (step) begin
            if (is_div) begin
                hi <= ge ? diff : shifted[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ge};
            end else begin
                hi <= sum[WIDTH:1];
                lo <= {sum[0], lo[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: hazard stall, MT*/MF* moves, and the FSM that sequences
// the iterative multiply/divide core and writes back in FIX.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic              Clk,
    input logic              Rst_n,
    hilo_muldiv_unit_if.slave bus
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q;
    logic               neg_q, rneg_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               accept, load, step, write;
    logic               sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   core_hi, core_lo;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod, res;

    assign bus.Stall = bus.Valid && state_q != IDLE;
    assign accept    = bus.Valid && !bus.Stall;
    assign bus.Busy  = state_q != IDLE;
    assign bus.Hi    = hi_q;
    assign bus.Lo    = lo_q;
    assign bus.Done  = done_q;

    assign bus.ReadValid = accept &&
        (bus.Op == OP_MFHI || bus.Op == OP_MFLO);
    assign bus.ReadData  = !bus.ReadValid ? '0 :
        (bus.Op == OP_MFHI ? hi_q : lo_q);

    assign sgn   = is_signed_op(bus.Op);
    assign a_mag = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .load   (load),
        .step   (step),
        .is_div (state_q == DIV),
        .a      (a_mag),
        .b      (b_mag),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        write   = 1'b0;
        if (bus.Flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && is_mul_op(bus.Op)) begin
                        load    = 1'b1;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = MUL;
                    end else if (accept && is_div_op(bus.Op)) begin
                        load    = 1'b1;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = DIV;
                    end
                end
                MUL, DIV: begin
                    step = 1'b1;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                FIX: begin
                    write   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Remainder follows the dividend sign, which also makes B=0 give Hi=A
    always_comb begin
        prod = {core_hi, core_lo};
        if (neg_q) prod = -prod;
        quo  = neg_q ? -core_lo : core_lo;
        rem  = rneg_q ? -core_hi : core_hi;
        unique case (op_q)
            OP_MADD: res = {hi_q, lo_q} + prod;
            OP_MSUB: res = {hi_q, lo_q} - prod;
            OP_DIV, OP_DIVU: res = {rem, dz_q ? '1 : quo};
            default: res = prod;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= write;
            if (load) begin
                op_q   <= bus.Op;
                neg_q  <= sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                rneg_q <= sgn && bus.A[WIDTH-1];
                dz_q   <= bus.B == '0;
            end
            if (write) begin
                {hi_q, lo_q} <= res;
            end else if (accept && !bus.Flush) begin
                if (bus.Op == OP_MTHI) hi_q <= bus.A;
                if (bus.Op == OP_MTLO) lo_q <= bus.A;
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed timing/hazard cases
// plus randomized ops against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] m_hl = '0;
    logic [63:0] exp_res[$];
    logic [31:0] exp_rd[$];

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();
    hilo_muldiv_unit_if #(.WIDTH(8))  bus8 ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    hilo_muldiv_unit #(.WIDTH(8)) dut8 (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [63:0] hl);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_MADD:  return hl + 64'(sa * sb);
            OP_MSUB:  return hl - 64'(sa * sb);
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, hl[31:0]};
            OP_MTLO: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    function automatic logic is_compute(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Done) begin
                if (exp_res.size() == 0)
                    check("done_unexpected", 64'd1, 64'd0);
                else
                    check("result_hilo", {bus.Hi, bus.Lo},
                          exp_res.pop_front());
            end
            if (bus.ReadValid) begin
                if (exp_rd.size() == 0)
                    check("read_unexpected", 64'd1, 64'd0);
                else
                    check("read_data", 64'(bus.ReadData),
                          64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.Busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.Valid = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.Valid = 1'b0;
        bus.Op    = OP_NONE;
    endtask

    task automatic do_op(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        logic [63:0] nx;
        wait_idle();
        nx = ref_model(op, a, b, m_hl);
        if (is_compute(op)) exp_res.push_back(nx);
        if (op == OP_MFHI) exp_rd.push_back(m_hl[63:32]);
        if (op == OP_MFLO) exp_rd.push_back(m_hl[31:0]);
        m_hl = nx;
        issue(op, a, b);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [12];
        int first, last, dcyc, dn, free, bad;

        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD,
                OP_MSUB, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO,
                OP_NONE, 4'd13};
        bus.Valid = 0; bus.Op = 0; bus.A = 0; bus.B = 0;
        bus.Flush = 0;
        bus8.Valid = 0; bus8.Op = 0; bus8.A = 0; bus8.B = 0;
        bus8.Flush = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(bus.Busy), 64'd0);

        // 8-bit instance: MULTU 0xFF*0xFF
        @(posedge clk);
        #1;
        bus8.Valid = 1; bus8.Op = OP_MULTU;
        bus8.A = 8'hFF; bus8.B = 8'hFF;
        @(posedge clk);
        #1;
        bus8.Valid = 0; bus8.Op = OP_NONE;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("w8_c9_busy_done", {bus8.Busy, bus8.Done}, 64'b10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w8_c10_hilo", {bus8.Hi, bus8.Lo}, 64'hFE01);
        check("w8_c10_done", {bus8.Busy, bus8.Done}, 64'b01);

        // MULT timing: busy window and single Done pulse
        do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        first = -1; last = -1; dcyc = -1; dn = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.Busy) begin
                if (first < 0) first = k;
                last = k;
            end
            if (bus.Done) begin
                dn++;
                dcyc = k;
            end
        end
        check("mult_busy_first", 64'(first), 64'd1);
        check("mult_busy_last", 64'(last), 64'd33);
        check("mult_done_cycle", 64'(dcyc), 64'd34);
        check("mult_done_count", 64'(dn), 64'd1);
        check("mult_hilo", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("div_neg7_2", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(OP_DIVU, 32'd100, 32'd0);
        wait_idle();
        check("divu_by_zero", {bus.Hi, bus.Lo}, 64'h0000_0064_FFFF_FFFF);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("div_ovf", {bus.Hi, bus.Lo}, 64'h0000_0000_8000_0000);

        // MFHI stalled behind a MULT
        do_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0F00);
        exp_rd.push_back(m_hl[63:32]);
        repeat (4) @(posedge clk);
        #1;
        bus.Valid = 1; bus.Op = OP_MFHI;
        free = -1; bad = 0;
        for (int cyc = 5; cyc < 100; cyc++) begin
            @(negedge clk);
            if (!bus.Stall) begin
                free = cyc;
                break;
            end
            if (bus.ReadValid) bad++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.Valid = 0; bus.Op = OP_NONE;
        check("mfhi_free_cycle", 64'(free), 64'd34);
        check("mfhi_rv_during_stall", 64'(bad), 64'd0);

        // MTLO / MADD / MSUB accumulate
        do_op(OP_MTHI, 32'd0, 32'd0);
        do_op(OP_MTLO, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("mtlo_lo", 64'(bus.Lo), 64'h1234_5678);
        do_op(OP_MADD, 32'd2, 32'd3);
        wait_idle();
        check("madd_hilo", {bus.Hi, bus.Lo}, 64'h0000_0000_1234_567E);
        do_op(OP_MSUB, 32'd1, 32'h7E);
        wait_idle();
        check("msub_hilo", {bus.Hi, bus.Lo}, 64'h0000_0000_1234_5600);

        // Flush at cycle 10 of a DIV
        wait_idle();
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        bus.Flush = 1;
        @(posedge clk);
        #1;
        bus.Flush = 0;
        @(negedge clk);
        check("flush_busy", 64'(bus.Busy), 64'd0);
        check("flush_hilo", {bus.Hi, bus.Lo}, m_hl);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Done) dn++;
        end
        check("flush_no_done", 64'(dn), 64'd0);

        // Flush beats a simultaneous MTHI
        @(posedge clk);
        #1;
        bus.Valid = 1; bus.Op = OP_MTHI; bus.A = 32'hCAFE_F00D;
        bus.Flush = 1;
        @(posedge clk);
        #1;
        bus.Valid = 0; bus.Op = OP_NONE; bus.Flush = 0;
        @(negedge clk);
        check("flush_mthi_hi", 64'(bus.Hi), 64'(m_hl[63:32]));

        // Async reset mid-MULT
        do_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        issue(OP_MULT, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        m_hl = '0;
        #2;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_hilo", {bus.Hi, bus.Lo}, 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            do_op(ops[$urandom_range(0, 11)], rnd_val(), rnd_val());
        end
        wait_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_hilo", {bus.Hi, bus.Lo}, m_hl);
        check("res_queue_drained", 64'(exp_res.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised sequential successor to the combinational controller's HI/LO path (WriteHi/WriteLo/HiOrLo).
- Owns the HI and LO registers and runs iterative signed/unsigned multiply, divide, MADD and MSUB at one bit per cycle.
- Serves MTHI/MTLO/MFHI/MFLO and raises Stall to the pipeline while a result is pending.
- Sits beside the ALU in EX, driven by decoded op codes from the controller.

Parameters:
WIDTH, 32, operand/HI/LO width; must be even and at least 4.
CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
Clk  in  1  clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
Valid  in  1  an instruction for this unit is presented this cycle.
Op  in  4  operation code from the shared package.
A  in  WIDTH  rs operand (multiplicand / dividend / move source).
B  in  WIDTH  rt operand (multiplier / divisor).
Flush  in  1  cancels any in-flight operation.
Stall  out  1  request not accepted; hold the pipeline.
Busy  out  1  an operation is in flight (state != IDLE).
ReadData  out  WIDTH  HI or LO value for MFHI/MFLO.
ReadValid  out  1  ReadData is valid this cycle.
Hi  out  WIDTH  current HI register.
Lo  out  WIDTH  current LO register.
Done  out  1  one-cycle pulse; HI/LO were written by a mul/div/madd/msub.

Behaviour:
- Reset (async, Rst_n=0) clears: state=IDLE, Hi=0, Lo=0, counter=0, datapath registers=0, Done=0. Reset applied mid-operation abandons the operation with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- Accept = Valid & !Stall. Stall = Valid & (state != IDLE). This covers every op, including MF*/MT*, so no WAW or RAW hazard can occur on HI/LO.
- MTHI/MTLO: when accepted, Hi (or Lo) <= A at that edge. No state change.
- MFHI/MFLO: when accepted, ReadValid=1 and ReadData=Hi (or Lo), combinationally in the same cycle. Otherwise ReadValid=0 and ReadData=0.
- MULT/MULTU/MADD/MSUB, accepted at edge t:
  - Latch operands. Signed ops latch magnitudes plus a negate flag (sign(A) XOR sign(B)).
  - Counter = WIDTH-1; go to MUL.
  - Each MUL cycle performs one shift-add step. Leave MUL when the counter reaches 0 (WIDTH steps, edges t+1..t+WIDTH).
  - FIX at edge t+WIDTH+1: apply the conditional negate to the 2*WIDTH product, then write {Hi,Lo}. MULT/MULTU write the product; MADD writes {Hi,Lo}+product; MSUB writes {Hi,Lo}-product. Both accumulate modulo 2^(2*WIDTH) and are signed.
  - Done=1 for the cycle after the FIX edge; state returns to IDLE on that same edge.
- DIV/DIVU: same timing via the DIV state using restoring division, one quotient bit per cycle.
  - In FIX: quotient is negated if the operand signs differ; remainder takes the dividend's sign. Lo=quotient, Hi=remainder.
  - B=0: Lo = all ones, Hi = A. Still takes the full latency and still pulses Done.
  - Signed most-negative / -1: Lo = most-negative (wraps), Hi=0.
- Total latency: result visible on Hi/Lo at cycle t+WIDTH+2 after the accept edge t. Busy is high in cycles t+1 .. t+WIDTH+1.
- Flush (synchronous, highest priority after reset): state <= IDLE with no HI/LO write and no Done.
  - Flush in the FIX cycle also suppresses the write.
  - Flush takes priority over a simultaneous accept: Stall is still computed, but nothing is latched and MT* is not written.
- Invalid Op while Valid in IDLE: accepted as a no-op.

Decomposition:
- Package hilo_pkg:
  - Op encodings (4-bit): OP_NONE=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MADD=5, OP_MSUB=6, OP_MTHI=7, OP_MTLO=8, OP_MFHI=9, OP_MFLO=10.
  - State encoding (2-bit): IDLE/MUL/DIV/FIX.
- One sub-module: hilo_iter_core, the shared shift-add / restoring-divide datapath (one step per enable, with an is_div select). The FSM, HI/LO registers and hazard logic stay in the top.

Test Plan:
- Reset, then OP_MULT A=7, B=0xFFFFFFFD at edge 0 -> Busy cycles 1..33; cycle 34: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done pulse in cycle 34 only.
- OP_DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. OP_DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100.
- OP_MFHI presented at cycle 5 of a MULT -> Stall=1, ReadValid=0 through cycle 33; in cycle 34 (IDLE) -> Stall=0, ReadValid=1, ReadData=new Hi.
- OP_MTLO A=0x12345678 in IDLE -> Lo=0x12345678 the next cycle. Then OP_MADD A=2, B=3 -> {Hi,Lo}=0x00000000_1234567E. Then OP_MSUB A=1, B=0x7E -> Lo=0x12345600.
- Flush at cycle 10 of a DIV, and separately Rst_n low mid-MULT -> IDLE next cycle (immediately for reset); Hi/Lo unchanged (reset: 0); no Done.
- WIDTH=8 instance: OP_MULTU A=0xFF, B=0xFF -> Hi=0xFE, Lo=0x01 at cycle 10.
